// File: rtl/ad7606_frame_avg_pkg.sv
// Shared constants and FSM encoding for the AD7606 frame averager.
// Channel indices are always IDX_W bits so up to 8 channels fit.
package ad7606_frame_avg_pkg;

  localparam int AD_CH_NUM = 8;
  localparam int AD_DATA_W = 16;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Frame counter width; stays 1 bit in pass-through mode so the vector is legal.
  function automatic int frame_cnt_w(input int avg_log2);
    return (avg_log2 < 1) ? 1 : avg_log2;
  endfunction

endpackage

// File: rtl/ad7606_frame_avg_ch_accum.sv
// Per-channel accumulator bank: sums sign-extended samples and returns the
// arithmetic-shifted average of the selected channel.
module ad_ch_accum
  import ad7606_frame_avg_pkg::*;
#(
  parameter int CH_NUM   = AD_CH_NUM,
  parameter int DATA_W   = AD_DATA_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              add_en,
  input  logic [IDX_W-1:0]  add_idx,
  input  logic [DATA_W-1:0] add_data,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic signed [ACC_W-1:0] acc [CH_NUM];
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] rd_sel;

  assign sample_ext = ACC_W'($signed(add_data));

  // NOTE: the bank is a handful of flops, not a RAM, so it is cleared on reset;
  // a partial sum from an abandoned frame must never reach the next average.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < CH_NUM; i++) acc[i] <= '0;
    end else if (add_en) begin
      for (int i = 0; i < CH_NUM; i++)
        if (add_idx == IDX_W'(i)) acc[i] <= acc[i] + sample_ext;
    end
  end

  // NOTE: rd_sel gets a default before the loop so no latch is inferred.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < CH_NUM; i++)
      if (rd_idx == IDX_W'(i)) rd_sel = acc[i];
  end

  // Arithmetic shift floors toward -inf; the sum cannot overflow ACC_W.
  assign rd_data = DATA_W'(rd_sel >>> AVG_LOG2);

endmodule

// File: rtl/ad7606_frame_avg.sv
// Drains 8-channel frames from the AD7606 FIFO, boxcar-averages 2**AVG_LOG2
// frames per channel and streams the averages out over valid/ready.
module ad7606_frame_avg
  import ad7606_frame_avg_pkg::*;
#(
  parameter int CH_NUM   = AD_CH_NUM,
  parameter int DATA_W   = AD_DATA_W,
  parameter int AVG_LOG2 = 2,
  parameter int USED_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [USED_W-1:0] fifo_rdusedw,
  output logic              fifo_rdreq,
  input  logic [DATA_W-1:0] fifo_q,
  output logic [DATA_W-1:0] ch_data,
  output logic [IDX_W-1:0]  ch_idx,
  output logic              ch_valid,
  input  logic              ch_ready,
  output logic              frame_done,
  output logic              ovf_sticky
);

  localparam int                FC_W     = frame_cnt_w(AVG_LOG2);
  localparam logic [FC_W-1:0]   FC_LAST  = FC_W'((1 << AVG_LOG2) - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(CH_NUM - 1);
  localparam logic [USED_W-1:0] USED_MIN = USED_W'(CH_NUM);

  state_t            state;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  cap_idx;
  logic              cap_en;
  logic [FC_W-1:0]   frame_cnt;
  logic              out_clr;

  // Last channel handed over: wipe the bank on the same edge the FSM leaves OUT.
  assign out_clr = (state == ST_OUT) && ch_ready && (ch_idx == IDX_LAST);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, which the read/capture skew relies on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      fifo_rdreq <= 1'b0;
      rd_idx     <= '0;
      cap_idx    <= '0;
      cap_en     <= 1'b0;
      frame_cnt  <= '0;
      ch_idx     <= '0;
      ch_valid   <= 1'b0;
      frame_done <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Non-show-ahead FIFO: the word for a read appears one cycle later.
      cap_en     <= fifo_rdreq;
      cap_idx    <= rd_idx;
      if (&fifo_rdusedw) ovf_sticky <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (enable && (fifo_rdusedw >= USED_MIN)) begin
            state      <= ST_READ;
            fifo_rdreq <= 1'b1;
            rd_idx     <= '0;
          end
        end
        ST_READ: begin
          if (rd_idx == IDX_LAST) begin
            fifo_rdreq <= 1'b0;
            state      <= ST_DRAIN;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (frame_cnt == FC_LAST) begin
            state    <= ST_OUT;
            ch_valid <= 1'b1;
            ch_idx   <= '0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (ch_ready) begin
            if (ch_idx == IDX_LAST) begin
              ch_valid   <= 1'b0;
              ch_idx     <= '0;
              frame_cnt  <= '0;
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              ch_idx <= ch_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ad_ch_accum #(
    .CH_NUM   (CH_NUM),
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk      (clk),
    .reset    (reset),
    .add_en   (cap_en),
    .add_idx  (cap_idx),
    .add_data (fifo_q),
    .clr      (out_clr),
    .rd_idx   (ch_idx),
    .rd_data  (ch_data)
  );

endmodule

// File: tb/tb_ad7606_frame_avg.sv
// Scoreboard bench: a pass-through instance and a 4-frame averaging instance,
// each fed by a small FIFO model, with negedge monitors checking the output stream.
module tb_ad7606_frame_avg;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic        enable0 = 1'b0, enable2 = 1'b0;
  logic [5:0]  rdusedw0, rdusedw2;
  logic        rdreq0, rdreq2;
  logic [15:0] q0 = '0, q2 = '0;
  logic [15:0] ch_data0, ch_data2;
  logic [2:0]  ch_idx0, ch_idx2;
  logic        ch_valid0, ch_valid2;
  logic        ch_ready0 = 1'b1;
  logic        ch_ready2;
  logic        frame_done0, frame_done2;
  logic        ovf0, ovf2;

  ad7606_frame_avg #(.CH_NUM(8), .DATA_W(16), .AVG_LOG2(0), .USED_W(6)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable0), .fifo_rdusedw(rdusedw0),
    .fifo_rdreq(rdreq0), .fifo_q(q0), .ch_data(ch_data0), .ch_idx(ch_idx0),
    .ch_valid(ch_valid0), .ch_ready(ch_ready0), .frame_done(frame_done0),
    .ovf_sticky(ovf0)
  );

  ad7606_frame_avg #(.CH_NUM(8), .DATA_W(16), .AVG_LOG2(2), .USED_W(6)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .fifo_rdusedw(rdusedw2),
    .fifo_rdreq(rdreq2), .fifo_q(q2), .ch_data(ch_data2), .ch_idx(ch_idx2),
    .ch_valid(ch_valid2), .ch_ready(ch_ready2), .frame_done(frame_done2),
    .ovf_sticky(ovf2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // FIFO models: usedw follows pushes minus pops, q updates the edge after rdreq.
  logic [15:0] fq0[$], fq2[$];
  int pushed0 = 0, popped0 = 0, pushed2 = 0, popped2 = 0;
  bit frc0 = 1'b0;

  function automatic logic [5:0] sat_used(input int n);
    return (n > 62) ? 6'd62 : 6'(n);
  endfunction

  assign rdusedw0 = frc0 ? 6'h3f : sat_used(pushed0 - popped0);
  assign rdusedw2 = sat_used(pushed2 - popped2);

  always @(posedge clk) begin
    if (rdreq0 && fq0.size() > 0) begin q0 <= fq0.pop_front(); popped0 <= popped0 + 1; end
    if (rdreq2 && fq2.size() > 0) begin q2 <= fq2.pop_front(); popped2 <= popped2 + 1; end
  end

  task automatic push0(input logic [15:0] w); fq0.push_back(w); pushed0++; endtask
  task automatic push2(input logic [15:0] w); fq2.push_back(w); pushed2++; endtask

  // ch_ready2 either follows a level or toggles every cycle.
  bit   tog2 = 1'b0;
  logic rdy_lvl2 = 1'b1;
  initial begin
    ch_ready2 = 1'b1;
    forever begin
      @(posedge clk); #1;
      ch_ready2 = tog2 ? ~ch_ready2 : rdy_lvl2;
    end
  end

  exp_t exp0[$], exp2[$];
  exp_t sv0, sv2, e0, e2;
  bit   stall0 = 0, stall2 = 0, pend0 = 0, pend2 = 0;
  int   run0 = 0, run2 = 0, done0 = 0, done2 = 0;

  always @(negedge clk) begin
    if (reset) begin
      stall0 = 0; pend0 = 0; run0 = 0;
    end else begin
      if (rdreq0) run0++;
      else if (run0 != 0) begin check(run0 == 8, "rdreq_run0", run0, 8); run0 = 0; end
      if (pend0 || frame_done0) check(frame_done0 == pend0, "frame_done0", frame_done0, pend0);
      if (frame_done0) done0++;
      pend0 = 0;
      if (ch_valid0) begin
        check(!rdreq0, "rdreq_in_out0", rdreq0, 0);
        if (stall0) check({ch_idx0, ch_data0} == sv0, "stall_hold0", {ch_idx0, ch_data0}, sv0);
        if (ch_ready0) begin
          check(exp0.size() > 0, "out0_expected", exp0.size(), 1);
          if (exp0.size() > 0) begin
            e0 = exp0.pop_front();
            check({ch_idx0, ch_data0} == e0, "out0", {ch_idx0, ch_data0}, e0);
          end
          pend0 = (ch_idx0 == 3'd7);
        end
        stall0 = !ch_ready0;
        sv0    = {ch_idx0, ch_data0};
      end else stall0 = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stall2 = 0; pend2 = 0; run2 = 0;
    end else begin
      if (rdreq2) run2++;
      else if (run2 != 0) begin check(run2 == 8, "rdreq_run2", run2, 8); run2 = 0; end
      if (pend2 || frame_done2) check(frame_done2 == pend2, "frame_done2", frame_done2, pend2);
      if (frame_done2) done2++;
      pend2 = 0;
      if (ch_valid2) begin
        check(!rdreq2, "rdreq_in_out2", rdreq2, 0);
        if (stall2) check({ch_idx2, ch_data2} == sv2, "stall_hold2", {ch_idx2, ch_data2}, sv2);
        if (ch_ready2) begin
          check(exp2.size() > 0, "out2_expected", exp2.size(), 1);
          if (exp2.size() > 0) begin
            e2 = exp2.pop_front();
            check({ch_idx2, ch_data2} == e2, "out2", {ch_idx2, ch_data2}, e2);
          end
          pend2 = (ch_idx2 == 3'd7);
        end
        stall2 = !ch_ready2;
        sv2    = {ch_idx2, ch_data2};
      end else stall2 = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_rdreq(input int d, input logic lvl, input int budget, input string name);
    int n = 0;
    while ((((d == 0) ? rdreq0 : rdreq2) !== lvl) && n < budget) begin
      @(negedge clk); n++;
    end
    check(n < budget, name, n, budget);
  endtask

  task automatic wait_done(input int d, input int target, input int budget, input string name);
    int n = 0;
    while ((((d == 0) ? done0 : done2) < target) && n < budget) begin
      @(negedge clk); n++;
    end
    check(n < budget, name, n, budget);
  endtask

  logic [15:0] avg_in [8][4];
  logic [15:0] avg_out[8];

  initial begin : stim
    int seen;

    avg_in[0] = '{16'd100, 16'd200, 16'd300, 16'd403};   avg_out[0] = 16'd250;
    avg_in[1] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000}; avg_out[1] = 16'h8000;
    avg_in[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000}; avg_out[2] = 16'hFFFF;
    avg_in[3] = '{16'd1, 16'd1, 16'd1, 16'd0};           avg_out[3] = 16'd0;
    avg_in[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}; avg_out[4] = 16'h7FFF;
    avg_in[5] = '{16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8}; avg_out[5] = 16'hFFF9;
    avg_in[6] = '{16'd10, 16'd20, 16'd30, 16'd40};       avg_out[6] = 16'd25;
    avg_in[7] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000}; avg_out[7] = 16'h048D;

    // Reset state.
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check({rdreq0, ch_valid0, frame_done0, ovf0} == 4'b0, "rst_flags0", {rdreq0, ch_valid0, frame_done0, ovf0}, 0);
    check(ch_data0 == 16'h0, "rst_data0", ch_data0, 0);
    check(ch_idx0 == 3'd0, "rst_idx0", ch_idx0, 0);
    check({rdreq2, ch_valid2, frame_done2, ovf2} == 4'b0, "rst_flags2", {rdreq2, ch_valid2, frame_done2, ovf2}, 0);
    check(ch_data2 == 16'h0, "rst_data2", ch_data2, 0);
    check(ch_idx2 == 3'd0, "rst_idx2", ch_idx2, 0);
    step();
    reset = 1'b0;

    // Pass-through frame 0x0001..0x0008.
    for (int n = 0; n < 8; n++) begin
      push0(16'(n + 1));
      exp0.push_back('{idx: 3'(n), data: 16'(n + 1)});
    end
    enable0 = 1'b1;
    wait_rdreq(0, 1'b1, 20, "pt_start");
    wait_done(0, 1, 100, "pt_done");
    repeat (3) @(negedge clk);
    check(done0 == 1, "pt_one_done", done0, 1);

    // 7 words available: no read; the 8th word starts a read one cycle later.
    step();
    for (int n = 0; n < 7; n++) begin
      push0(16'h0010 + 16'(n));
      exp0.push_back('{idx: 3'(n), data: 16'h0010 + 16'(n)});
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (rdreq0) seen++; end
    check(seen == 0, "no_read_at_7", seen, 0);
    step();
    push0(16'h0017);
    exp0.push_back('{idx: 3'd7, data: 16'h0017});
    @(negedge clk);
    check(rdreq0 == 1'b0, "lat_pre", rdreq0, 0);
    @(negedge clk);
    check(rdreq0 == 1'b1, "lat_start", rdreq0, 1);
    wait_done(0, 2, 100, "lat_done");

    // Overflow flag sets on rdusedw all-ones and holds.
    enable0 = 1'b0;
    step();
    @(negedge clk);
    check(ovf0 == 1'b0, "ovf_pre", ovf0, 0);
    step();
    frc0 = 1'b1;
    step();
    frc0 = 1'b0;
    @(negedge clk);
    check(ovf0 == 1'b1, "ovf_set", ovf0, 1);
    repeat (5) step();
    @(negedge clk);
    check(ovf0 == 1'b1, "ovf_hold", ovf0, 1);
    check(ovf2 == 1'b0, "ovf_indep", ovf2, 0);

    // Reset during the 4th read cycle; the next frame realigns to ch0.
    step();
    enable0 = 1'b1;
    for (int n = 0; n < 8; n++) push0(16'h00A0 + 16'(n));
    wait_rdreq(0, 1'b1, 20, "rst_frame_start");
    repeat (3) step();
    reset   = 1'b1;
    enable0 = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check(rdreq0 == 1'b0, "rst_mid_rdreq", rdreq0, 0);
    check({ch_valid0, frame_done0, ovf0} == 3'b0, "rst_mid_flags", {ch_valid0, frame_done0, ovf0}, 0);
    check(ch_data0 == 16'h0, "rst_mid_data", ch_data0, 0);
    step();
    fq0.delete();
    pushed0 = popped0;
    for (int n = 0; n < 8; n++) begin
      push0(16'h0B00 + 16'(n));
      exp0.push_back('{idx: 3'(n), data: 16'h0B00 + 16'(n)});
    end
    enable0 = 1'b1;
    wait_done(0, 3, 100, "realign_done");

    // Four-frame average with ch_ready toggling in OUT.
    step();
    tog2 = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 8; n++) push2(avg_in[n][f]);
    for (int n = 0; n < 8; n++) exp2.push_back('{idx: 3'(n), data: avg_out[n]});
    enable2 = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_rdreq(2, 1'b1, 30, "avg_frame_start");
      check(ch_valid2 == 1'b0, "avg_valid_low", ch_valid2, 0);
      wait_rdreq(2, 1'b0, 30, "avg_frame_end");
    end
    wait_done(2, 1, 200, "avg_done");

    // Second averaging set with ready held high; the bank must start from zero.
    tog2     = 1'b0;
    rdy_lvl2 = 1'b1;
    step();
    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 8; n++) push2(16'(n * 4 + f));
    for (int n = 0; n < 8; n++) exp2.push_back('{idx: 3'(n), data: 16'(n * 4 + 1)});
    wait_done(2, 2, 300, "avg2_done");

    // enable dropped mid-read: the frame completes, nothing more is read.
    step();
    for (int n = 0; n < 16; n++) push0(16'h0C00 + 16'(n));
    for (int n = 0; n < 8; n++) exp0.push_back('{idx: 3'(n), data: 16'h0C00 + 16'(n)});
    wait_rdreq(0, 1'b1, 20, "dis_start");
    repeat (3) step();
    enable0 = 1'b0;
    wait_done(0, 4, 100, "dis_done");
    seen = 0;
    repeat (30) begin @(negedge clk); if (rdreq0) seen++; end
    check(seen == 0, "no_read_after_disable", seen, 0);
    check(pushed0 - popped0 == 8, "fifo_left", pushed0 - popped0, 8);

    check(exp0.size() == 0, "exp0_drained", exp0.size(), 0);
    check(exp2.size() == 0, "exp2_drained", exp2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
